uart_word_tx: RTL
=================

Name: uart_word_tx

Overview:
- Transmit-side partner of the UART word receiver. Takes a WIDTH_DIN-bit result word (for example the coprocessor's dout/dout_valid) and sends it byte by byte on a UART TX line, 8N1.
- Holds one pending word so the compute side can issue a second result while the current one is still being sent.
- Sits between the compute block and the board's UART TX pin.

Parameters:
- WIDTH_DIN, 128, word width in bits. Must be a multiple of 8. NBYTES = WIDTH_DIN/8.
- CLKS_PER_BIT, 104, clk cycles per UART bit. Must be >= 2. Default gives 115200 baud at 12 MHz.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH_DIN  word to transmit.
- din_valid  in  1  word offer, single-cycle qualifier.
- din_ready  out  1  pending slot empty; registered.
- tx  out  1  UART serial out, idle high; registered.
- busy  out  1  high while a word is shifting or the pending slot is full.
- overflow  out  1  sticky: a word was offered while din_ready=0.
- words_sent  out  8  count of completed words, wraps 255->0.

Behaviour:
- Reset (async assert, sync deassert internally):
  - Outputs: tx=1, din_ready=1, busy=0, overflow=0, words_sent=0.
  - Internal: pending and shifter empty, FSM in IDLE.
  - Reset asserted mid-frame abandons the frame and drives tx=1 immediately.
- Accept rule:
  - A word is accepted on an edge where din_valid=1 and din_ready=1; din is copied into the pending register and pending_full is set.
  - din_valid=1 with din_ready=0 drops the word and sets overflow. overflow is cleared only by reset.
  - No bypass path: din_ready depends only on pending_full.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if pending_full, load the shifter from pending, clear pending_full, go to START. Driving tx=0 is registered on that same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each bit CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - more bytes remain: START of the next byte with no idle gap;
    - word done and pending_full: load pending and go to START directly (no IDLE cycle);
    - otherwise: IDLE.
- Byte order: most significant byte first; din[WIDTH_DIN-1 -: 8] goes out first.
- Baud counter runs 0..CLKS_PER_BIT-1 and resets on every bit boundary, so every bit is exactly CLKS_PER_BIT cycles.
- Latency:
  - Word accepted at edge E into an idle block: tx falls at edge E+1.
  - Word duration is NBYTES*10*CLKS_PER_BIT cycles.
  - words_sent increments on the edge that ends the last stop bit.
- busy = (state != IDLE) | pending_full.
- Simultaneous events:
  - The edge where the shifter loads from pending sets din_ready=1 from the next cycle. An offer on that same edge sees din_ready=0 and is dropped (overflow).
  - din is ignored while din_valid=0.

Optional Feature:
- Macro: UART_WORD_TX_HEX_EN.
- Defined: each byte is sent as two ASCII uppercase hex characters, high nibble first, mapping 0-9 to 0x30-0x39 and A-F to 0x41-0x46. The word ends with CR (0x0D) then LF (0x0A).
  - Characters per word = 2*NBYTES+2.
  - Word duration = (2*NBYTES+2)*10*CLKS_PER_BIT cycles.
  - words_sent increments after the LF stop bit.
- Undefined: raw binary bytes only, with no hex conversion logic.

Test Plan:
1. WIDTH_DIN=16, CLKS_PER_BIT=4, din=0xA55A single offer. Required:
   - tx falls 1 cycle after accept;
   - decoded bytes 0xA5 then 0x5A, each bit exactly 4 cycles, stop bits high;
   - busy drops after 80 cycles;
   - words_sent=1.
2. Back-to-back: offer 0x1234, then 0xBEEF 10 cycles later. Required:
   - second word held in pending, din_ready=0 until it loads;
   - tx stream 12 34 BE EF with no idle cycle between words;
   - total 160 cycles;
   - words_sent=2.
3. Overflow: with pending full, offer 0xFFFF. Required:
   - overflow=1 and stays 1;
   - 0xFFFF never appears on tx;
   - words_sent counts only the two accepted words.
4. Reset mid-DATA of the first byte. Required:
   - tx=1 in the same cycle as rst_n low;
   - busy=0, din_ready=1, words_sent=0;
   - next accepted word transmits cleanly.
5. Wrap: send 256 words. Required: words_sent returns to 0.
6. With UART_WORD_TX_HEX_EN, din=0x0A3F. Required:
   - tx bytes 0x30 0x41 0x33 0x46 0x0D 0x0A;
   - 240 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - word-to-UART 8N1 transmitter with one pending word slot
// Define UART_WORD_TX_HEX_EN to send each byte as two ASCII hex characters followed by CR LF.
module uart_word_tx #(
  parameter int WIDTH_DIN    = 128,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_DIN-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 overflow,
  output logic [7:0]           words_sent
);

  localparam int NBYTES = WIDTH_DIN / 8;
`ifdef UART_WORD_TX_HEX_EN
  localparam int NCHARS = 2 * NBYTES + 2;
  localparam int STEP   = 4;
`else
  localparam int NCHARS = NBYTES;
  localparam int STEP   = 8;
`endif
  localparam int CW = $clog2(NCHARS + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NCHARS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [CW-1:0]        char_idx;
  logic [WIDTH_DIN-1:0] shifter;
  logic [WIDTH_DIN-1:0] pending;
  logic                 pending_full;
  logic [7:0]           byte_sr;
  logic [7:0]           char_first;
  logic [7:0]           char_nxt;
  logic                 rst_meta;
  logic                 rst_sync;
  logic                 baud_end;
  logic                 word_end;
  logic                 load;

`ifdef UART_WORD_TX_HEX_EN
  logic [CW-1:0] char_nxt_idx;

  function automatic logic [7:0] hex_digit(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  assign char_nxt_idx = char_idx + CW'(1);

  always_comb begin
    char_first = hex_digit(pending[WIDTH_DIN-1 -: 4]);
    char_nxt   = hex_digit(shifter[WIDTH_DIN-1 -: 4]);
    if (char_nxt_idx == CW'(2 * NBYTES))          char_nxt = 8'h0D;
    else if (char_nxt_idx == CW'(2 * NBYTES + 1)) char_nxt = 8'h0A;
  end
`else
  always_comb begin
    char_first = pending[WIDTH_DIN-1 -: 8];
    char_nxt   = shifter[WIDTH_DIN-1 -: 8];
  end
`endif

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign word_end  = (state == STOP) && baud_end && (char_idx == CHAR_LAST);
  assign load      = pending_full && ((state == IDLE) || word_end);
  assign din_ready = ~pending_full;
  assign busy      = (state != IDLE) | pending_full;

  // Reset asserts immediately; release is held off two clocks so logic leaves reset cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      char_idx     <= '0;
      shifter      <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      byte_sr      <= '0;
      tx           <= 1'b1;
      overflow     <= 1'b0;
      words_sent   <= '0;
    end else if (rst_sync) begin
      if (din_valid) begin
        if (!pending_full) begin
          pending      <= din;
          pending_full <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (state != IDLE) baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);

      case (state)
        IDLE: ;
        START: begin
          if (baud_end) begin
            tx      <= byte_sr[0];
            byte_sr <= byte_sr >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= byte_sr[0];
              byte_sr <= byte_sr >> 1;
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            if (char_idx != CHAR_LAST) begin
              char_idx <= char_idx + CW'(1);
              byte_sr  <= char_nxt;
              shifter  <= shifter << STEP;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              words_sent <= words_sent + 8'd1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Loading from pending overrides the IDLE fall-through at the end of a word.
      if (load) begin
        shifter      <= pending << STEP;
        byte_sr      <= char_first;
        char_idx     <= '0;
        pending_full <= 1'b0;
        baud_cnt     <= '0;
        tx           <= 1'b0;
        state        <= START;
      end
    end
  end

endmodule
